// File: rtl/perf_pkg.sv
// Shared types and helpers for the rasterizer performance counter bank.
package perf_pkg;

    localparam int PERF_STATE_W = 2;
    localparam int POP_MAX_W    = 64;

    typedef enum logic [PERF_STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_FROZEN = 2'd3
    } perf_state_t;

    // Counts set bits in the low `width` bits of `bits`; callers zero-extend to POP_MAX_W.
    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] bits,
                                             input int unsigned          width);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < POP_MAX_W; i++) begin
            if (i < width && bits[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/dff.sv
// Pipeline register cell, asynchronously cleared to zero.
module dff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else     q <= d;
    end

endmodule

// File: rtl/perf_sat_counter.sv
// Saturating event counter with a sticky overflow flag.
module perf_sat_counter #(
    parameter int CNT_W = 32,
    parameter int INC_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [INC_W-1:0] inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam int SUM_W = CNT_W + 1;

    logic [SUM_W-1:0] sum;

    assign sum = {1'b0, count} + SUM_W'(inc);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (en) begin
            if (sum[CNT_W]) begin
                count <= '1;
                sat   <= 1'b1;
            end else begin
                count <= sum[CNT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// Performance counter bank observing the multi-lane sample-test pipeline.
// Define PERF_TRI_COUNT_EN to build the triangle-change delay lines and counter.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int LANES      = 2,
    parameter int CNT_W      = 32,
    parameter int PIPE_DEPTH = 3,
    parameter int WARMUP     = 3,
    parameter int WIN_W      = 20,
    parameter int SIGFIG     = 24,
    parameter int VERTS      = 3,
    parameter int AXIS       = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 stop,
    input  logic                                 clear,
    input  logic                                 snap_req,
    input  logic [WIN_W-1:0]                     window_len,
    input  logic [LANES-1:0]                     validSamp_R16H,
    input  logic [LANES-1:0]                     hit_valid_R18H,
    input  logic signed [VERTS*AXIS*SIGFIG-1:0]  tri_R16S,
    output logic [CNT_W-1:0]                     snap_sample,
    output logic [CNT_W-1:0]                     snap_hit,
    output logic [CNT_W-1:0]                     snap_tri,
    output logic [CNT_W-1:0]                     snap_cycle,
    output logic                                 report_valid,
    output logic                                 sat_flag,
    output logic [PERF_STATE_W-1:0]              state
);

    localparam int INC_W  = $clog2(LANES + 1);
    localparam int WARM_W = $clog2(WARMUP + 2);
    localparam int SUM_W  = CNT_W + 1;

    perf_state_t       state_q, state_d;
    logic [WARM_W-1:0] warm_q;
    logic              run, warm_load, warm_dec;
    logic [WIN_W-1:0]  win_q;
    logic              win_hit, fire;

    logic [PIPE_DEPTH:0][LANES-1:0] v_pipe;
    logic [LANES-1:0]  v_d;
    logic [INC_W-1:0]  samp_inc, hit_inc;
    logic [CNT_W-1:0]  samp_cnt, hit_cnt, cyc_cnt;
    logic              samp_sat, hit_sat, cyc_sat, tri_sat;

    // Value a counter will hold after this edge; lets a snapshot include the current cycle.
    function automatic logic [CNT_W-1:0] next_val(input logic [CNT_W-1:0] cnt,
                                                  input logic [CNT_W-1:0] inc,
                                                  input logic             en);
        logic [SUM_W-1:0] s;
        s = {1'b0, cnt} + {1'b0, inc};
        if (!en)     return cnt;
        if (s[CNT_W]) return '1;
        return s[CNT_W-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: default assignment first so no path through this block can infer a latch.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:   if (start) state_d = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
                ST_WARMUP: if (stop) state_d = ST_FROZEN;
                           else if (warm_q == WARM_W'(1)) state_d = ST_RUN;
                ST_RUN:    if (stop) state_d = ST_FROZEN;
                ST_FROZEN: if (start) state_d = ST_RUN;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        run       = (state_q == ST_RUN);
        warm_load = (state_q == ST_IDLE) && start && !clear;
        warm_dec  = (state_q == ST_WARMUP);
    end

    assign state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            warm_q <= '0;
        else if (clear)                     warm_q <= '0;
        else if (warm_load)                 warm_q <= WARM_W'(WARMUP);
        else if (warm_dec && warm_q != '0)  warm_q <= warm_q - 1'b1;
    end

    // The >= compare makes a shortened window fire on the very next RUN cycle.
    assign win_hit = run && (window_len != '0) && (win_q >= window_len - WIN_W'(1));
    assign fire    = (win_hit || snap_req) && !clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        win_q <= '0;
        else if (clear) win_q <= '0;
        else if (run)   win_q <= win_hit ? '0 : win_q + 1'b1;
    end

    assign v_pipe[0] = validSamp_R16H;
    for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_vdly
        dff #(.WIDTH(LANES)) u_dff (.clk(clk), .rst(rst), .d(v_pipe[i]), .q(v_pipe[i+1]));
    end
    assign v_d = v_pipe[PIPE_DEPTH];

    assign samp_inc = INC_W'(popcount(POP_MAX_W'(v_d), LANES));
    assign hit_inc  = INC_W'(popcount(POP_MAX_W'(v_d & hit_valid_R18H), LANES));

    perf_sat_counter #(.CNT_W(CNT_W), .INC_W(INC_W)) u_sample (
        .clk(clk), .rst(rst), .clr(clear), .en(run), .inc(samp_inc), .count(samp_cnt), .sat(samp_sat));
    perf_sat_counter #(.CNT_W(CNT_W), .INC_W(INC_W)) u_hit (
        .clk(clk), .rst(rst), .clr(clear), .en(run), .inc(hit_inc), .count(hit_cnt), .sat(hit_sat));
    perf_sat_counter #(.CNT_W(CNT_W), .INC_W(1)) u_cycle (
        .clk(clk), .rst(rst), .clr(clear), .en(run), .inc(1'b1), .count(cyc_cnt), .sat(cyc_sat));

    // Snapshots survive clear; only rst wipes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_sample  <= '0;
            snap_hit     <= '0;
            snap_cycle   <= '0;
            report_valid <= 1'b0;
        end else begin
            report_valid <= fire;
            if (fire) begin
                snap_sample <= next_val(samp_cnt, CNT_W'(samp_inc), run);
                snap_hit    <= next_val(hit_cnt, CNT_W'(hit_inc), run);
                snap_cycle  <= next_val(cyc_cnt, CNT_W'(1), run);
            end
        end
    end

`ifdef PERF_TRI_COUNT_EN
    localparam int TRI_W = VERTS * AXIS * SIGFIG;

    logic [PIPE_DEPTH:0][TRI_W-1:0] t_pipe;
    logic [TRI_W-1:0] tri_a, tri_b;
    logic             tri_inc;
    logic [CNT_W-1:0] tri_cnt;

    assign t_pipe[0] = tri_R16S;
    for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_tdly
        dff #(.WIDTH(TRI_W)) u_dff (.clk(clk), .rst(rst), .d(t_pipe[i]), .q(t_pipe[i+1]));
    end
    assign tri_a   = t_pipe[PIPE_DEPTH-1];
    assign tri_b   = t_pipe[PIPE_DEPTH];
    assign tri_inc = (tri_a != tri_b);

    perf_sat_counter #(.CNT_W(CNT_W), .INC_W(1)) u_tri (
        .clk(clk), .rst(rst), .clr(clear), .en(run), .inc(tri_inc), .count(tri_cnt), .sat(tri_sat));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       snap_tri <= '0;
        else if (fire) snap_tri <= next_val(tri_cnt, CNT_W'(tri_inc), run);
    end
`else
    logic unused_tri;

    assign unused_tri = ^tri_R16S;
    assign tri_sat    = 1'b0;
    assign snap_tri   = '0;
`endif

    assign sat_flag = samp_sat | hit_sat | cyc_sat | tri_sat;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Randomized and directed bench for perf_counter_bank against a behavioural model.
module tb_perf_counter_bank;

    localparam int PD   = 3;
    localparam int WARM = 3;
`ifdef PERF_TRI_COUNT_EN
    localparam bit TRI_EN = 1'b1;
`else
    localparam bit TRI_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, start, stop, clear, snap_req;
    logic [19:0] window_len;
    logic [1:0]  valid_a, hit_a;
    logic [2:0]  valid_b, hit_b;
    logic signed [215:0] tri_in;

    logic [31:0] a_sample, a_hit, a_tri, a_cycle;
    logic        a_rv, a_sat;
    logic [1:0]  a_state;
    logic [3:0]  b_sample, b_hit, b_tri, b_cycle;
    logic        b_rv, b_sat;
    logic [1:0]  b_state;

    always #5 clk = ~clk;

    perf_counter_bank dut_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .snap_req(snap_req),
        .window_len(window_len), .validSamp_R16H(valid_a), .hit_valid_R18H(hit_a), .tri_R16S(tri_in),
        .snap_sample(a_sample), .snap_hit(a_hit), .snap_tri(a_tri), .snap_cycle(a_cycle),
        .report_valid(a_rv), .sat_flag(a_sat), .state(a_state));

    perf_counter_bank #(.LANES(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .snap_req(snap_req),
        .window_len(window_len), .validSamp_R16H(valid_b), .hit_valid_R18H(hit_b), .tri_R16S(tri_in),
        .snap_sample(b_sample), .snap_hit(b_hit), .snap_tri(b_tri), .snap_cycle(b_cycle),
        .report_valid(b_rv), .sat_flag(b_sat), .state(b_state));

    // Reference model: index 0 = 2-lane/32-bit bank, 1 = 3-lane/4-bit bank; counters ordered sample, hit, tri, cycle.
    int              m_state, m_warm, m_win;
    bit              m_rv;
    bit              m_sat [2];
    longint unsigned m_cnt [2][4];
    longint unsigned m_snap[2][4];
    longint unsigned m_max [2] = '{64'hFFFF_FFFF, 64'd15};
    logic [1:0]      vq0[$];
    logic [2:0]      vq1[$];
    logic [215:0]    tq[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic logic [215:0] mk_tri(input int unsigned id);
        return {9{24'(id)}};
    endfunction

    task automatic model_reset();
        m_state = 0; m_warm = 0; m_win = 0; m_rv = 1'b0;
        for (int b = 0; b < 2; b++) begin
            m_sat[b] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_cnt[b][i]  = 0;
                m_snap[b][i] = 0;
            end
        end
        vq0.delete(); vq1.delete(); tq.delete();
        for (int i = 0; i < PD; i++) begin
            vq0.push_back(2'b0); vq1.push_back(3'b0); tq.push_back(216'b0);
        end
    endtask

    task automatic model_step();
        logic [1:0]      vd0;
        logic [2:0]      vd1;
        logic [215:0]    ta, tb;
        longint unsigned inc[2][4];
        bit              run, win_ev, fire;

        vd0 = vq0.pop_front(); vq0.push_back(valid_a);
        vd1 = vq1.pop_front(); vq1.push_back(valid_b);
        tb  = tq.pop_front();
        ta  = tq[0];
        tq.push_back(tri_in);

        inc[0][0] = 64'($countones(vd0));
        inc[0][1] = 64'($countones(vd0 & hit_a));
        inc[1][0] = 64'($countones(vd1));
        inc[1][1] = 64'($countones(vd1 & hit_b));
        for (int b = 0; b < 2; b++) begin
            inc[b][2] = 64'(TRI_EN && (ta != tb));
            inc[b][3] = 64'd1;
        end

        run    = (m_state == 2);
        win_ev = run && (window_len != 0) && (m_win >= int'(window_len) - 1);
        fire   = (win_ev || snap_req) && !clear;

        for (int b = 0; b < 2; b++) begin
            if (clear) begin
                for (int i = 0; i < 4; i++) m_cnt[b][i] = 0;
                m_sat[b] = 1'b0;
            end else if (run) begin
                for (int i = 0; i < 4; i++) begin
                    if (m_cnt[b][i] + inc[b][i] > m_max[b]) begin
                        m_cnt[b][i] = m_max[b];
                        m_sat[b]    = 1'b1;
                    end else begin
                        m_cnt[b][i] += inc[b][i];
                    end
                end
            end
            if (fire)
                for (int i = 0; i < 4; i++) m_snap[b][i] = m_cnt[b][i];
        end
        m_rv = fire;

        if (clear)    m_win = 0;
        else if (run) m_win = win_ev ? 0 : ((m_win + 1) & 32'hFFFFF);

        if (clear) begin
            m_state = 0;
            m_warm  = 0;
        end else begin
            case (m_state)
                0: if (start) begin
                       if (WARM == 0) m_state = 2;
                       else begin m_state = 1; m_warm = WARM; end
                   end
                1: if (stop) m_state = 3;
                   else begin
                       m_warm--;
                       if (m_warm == 0) m_state = 2;
                   end
                2: if (stop) m_state = 3;
                default: if (start) m_state = 2;
            endcase
        end
    endtask

    task automatic compare_all();
        check("a_state",  64'(a_state),  64'(m_state));
        check("b_state",  64'(b_state),  64'(m_state));
        check("a_report", 64'(a_rv),     64'(m_rv));
        check("b_report", 64'(b_rv),     64'(m_rv));
        check("a_sat",    64'(a_sat),    64'(m_sat[0]));
        check("b_sat",    64'(b_sat),    64'(m_sat[1]));
        check("a_sample", 64'(a_sample), m_snap[0][0]);
        check("a_hit",    64'(a_hit),    m_snap[0][1]);
        check("a_tri",    64'(a_tri),    m_snap[0][2]);
        check("a_cycle",  64'(a_cycle),  m_snap[0][3]);
        check("b_sample", 64'(b_sample), m_snap[1][0]);
        check("b_hit",    64'(b_hit),    m_snap[1][1]);
        check("b_tri",    64'(b_tri),    m_snap[1][2]);
        check("b_cycle",  64'(b_cycle),  m_snap[1][3]);
    endtask

    // One clock: DUT samples current inputs, model follows, outputs compared 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        int n_rep;
        int r;

        rst = 1'b1; start = 0; stop = 0; clear = 0; snap_req = 0;
        window_len = '0; valid_a = '0; hit_a = '0; valid_b = '0; hit_b = '0;
        tri_in = mk_tri(0);
        model_reset();
        #22;
        compare_all();
        rst = 1'b0;

        // Aligned sample/hit accounting over 10 RUN cycles.
        start = 1; tick(); start = 0;
        for (int k = 1; k <= 13; k++) begin
            valid_a  = (k <= 10) ? 2'b11 : 2'b00;
            hit_a    = (k >= 4) ? (((k - 4) % 2 == 1) ? 2'b11 : 2'b01) : 2'b00;
            snap_req = (k == 13);
            tick();
        end
        snap_req = 0; valid_a = '0; hit_a = '0;
        check("t1_sample", 64'(a_sample), 64'd20);
        check("t1_hit",    64'(a_hit),    64'd15);
        check("t1_cycle",  64'(a_cycle),  64'd10);
        check("t1_report", 64'(a_rv),     64'd1);

        // Periodic reports every 4 RUN cycles.
        clear = 1; tick(); clear = 0;
        window_len = 20'd4;
        start = 1; tick(); start = 0;
        n_rep = 0;
        for (int c = 0; c < 40 && n_rep < 3; c++) begin
            tick();
            if (a_rv) begin
                n_rep++;
                check("t2_win_cycle", 64'(a_cycle), 64'(4 * n_rep));
            end
        end
        check("t2_reports", 64'(n_rep), 64'd3);

        // Asynchronous reset in the middle of a window.
        repeat (2) tick();
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("rst_state",  64'(a_state),  64'd0);
        check("rst_cycle",  64'(a_cycle),  64'd0);
        check("rst_sample", 64'(a_sample), 64'd0);
        check("rst_report", 64'(a_rv),     64'd0);
        check("rst_sat",    64'(a_sat),    64'd0);
        repeat (2) begin
            @(posedge clk); #1;
            check("rst_no_report", 64'(a_rv), 64'd0);
        end
        rst = 1'b0;
        window_len = '0;

        // Stop for 5 cycles, then resume without warm-up.
        for (int k = 0; k <= 18; k++) begin
            start    = (k == 0 || k == 14);
            stop     = (k == 9);
            snap_req = (k == 18);
            tick();
            if (k == 14) check("t3_resume_run", 64'(a_state), 64'd2);
        end
        start = 0; stop = 0; snap_req = 0;
        check("t3_cycle", 64'(a_cycle), 64'd10);

        // Saturation of the 4-bit bank with 3 hits per cycle.
        clear = 1; tick(); clear = 0;
        for (int k = 0; k <= 9; k++) begin
            start    = (k == 0);
            valid_b  = (k >= 1 && k <= 6) ? 3'b111 : 3'b000;
            hit_b    = (k >= 4 && k <= 9) ? 3'b111 : 3'b000;
            snap_req = (k == 9);
            tick();
        end
        start = 0; snap_req = 0; valid_b = '0; hit_b = '0;
        check("t4_hit_clamp", 64'(b_hit), 64'd15);
        check("t4_sat_set",   64'(b_sat), 64'd1);
        clear = 1; tick(); clear = 0;
        check("t4_clr_state", 64'(b_state), 64'd0);
        check("t4_clr_sat",   64'(b_sat),   64'd0);

        // Triangle changes every 7 cycles over 28 RUN cycles.
        clear = 1; tick(); clear = 0;
        for (int k = 0; k <= 31; k++) begin
            start    = (k == 0);
            tri_in   = mk_tri(k / 7);
            snap_req = (k == 31);
            tick();
        end
        start = 0; snap_req = 0;
        check("t5_tri",   64'(a_tri),   TRI_EN ? 64'd4 : 64'd0);
        check("t5_cycle", 64'(a_cycle), 64'd28);

        // Randomized control and lane traffic.
        clear = 1; tick(); clear = 0;
        for (int c = 0; c < 2000; c++) begin
            r        = int'($urandom_range(0, 99));
            start    = (r < 6);
            stop     = (r >= 6 && r < 9);
            clear    = (r == 9);
            snap_req = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 49) == 0) window_len = 20'($urandom_range(0, 6));
            valid_a = 2'($urandom);
            hit_a   = 2'($urandom);
            valid_b = 3'($urandom);
            hit_b   = 3'($urandom);
            if ($urandom_range(0, 9) == 0) tri_in = mk_tri($urandom_range(0, 3));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
